// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and default constants for the serial pattern detector controller.
package seq_detect_ctrl_pkg;

  localparam int unsigned DefWordW = 8;
  localparam int unsigned DefPatW  = 4;
  localparam logic [DefPatW-1:0] DefRstPattern = 4'b1011;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } ctrl_state_t;

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: history shift register plus compare against the pattern.
module seq_match_core
  import seq_detect_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [FillW-1:0] fill_q, fill_d;
  logic             full;

  // fill_q counts fresh bits in history so an all-zero pattern cannot match cleared history.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    full       = (fill_q >= FillW'(PAT_W - 1));
    match      = bit_valid && full && (hist_shift == pattern);
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = full ? fill_q : fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-level controller: accepts words, streams them MSB-first into the match core and
// reports per-word match count and first-match position.
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned PAT_W  = DefPatW,
  parameter logic [PAT_W-1:0] RST_PATTERN = DefRstPattern,
  parameter int unsigned CNT_W  = $clog2(WORD_W + 1),
  parameter int unsigned POS_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_found,
  output logic [POS_W-1:0]  out_first_pos,
  output logic              busy
);

  ctrl_state_t       state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [POS_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [POS_W-1:0]  first_pos_q, first_pos_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              overlap_q, overlap_d;
  logic              core_clear, core_bit_valid, core_match;

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    bit_idx_d      = bit_idx_q;
    count_d        = count_q;
    first_pos_d    = first_pos_q;
    pattern_d      = pattern_q;
    overlap_d      = overlap_q;
    core_clear     = 1'b0;
    core_bit_valid = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        // Config lands on the same edge as a word accept, so that word sees the new setting.
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          overlap_d = cfg_overlap;
        end
        if (in_valid) begin
          word_d      = in_word;
          bit_idx_d   = '0;
          count_d     = '0;
          first_pos_d = '0;
          core_clear  = 1'b1;
          state_d     = StShift;
        end
      end
      StShift: begin
        core_bit_valid = 1'b1;
        word_d         = word_q << 1;
        if (core_match) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == '0) first_pos_d = bit_idx_q;
        end
        if (bit_idx_q == POS_W'(WORD_W - 1)) begin
          state_d = StReport;
        end else begin
          bit_idx_d = bit_idx_q + POS_W'(1);
        end
      end
      StReport: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      word_q      <= '0;
      bit_idx_q   <= '0;
      count_q     <= '0;
      first_pos_q <= '0;
      pattern_q   <= RST_PATTERN;
      overlap_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_idx_q   <= bit_idx_d;
      count_q     <= count_d;
      first_pos_q <= first_pos_d;
      pattern_q   <= pattern_d;
      overlap_q   <= overlap_d;
    end
  end

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_match_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (core_clear),
    .bit_valid(core_bit_valid),
    .bit_in   (word_q[WORD_W-1]),
    .pattern  (pattern_q),
    .overlap  (overlap_q),
    .match    (core_match)
  );

  assign out_count     = count_q;
  assign out_found     = (count_q != '0);
  assign out_first_pos = first_pos_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_count;
  logic       out_found;
  logic [2:0] out_first_pos;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_detect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_pattern  (cfg_pattern),
    .cfg_overlap  (cfg_overlap),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_found    (out_found),
    .out_first_pos(out_first_pos),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [3:0] pat, input logic ovl);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    tick();
    cfg_we = 1'b0;
  endtask

  // Drives one word, waits (bounded) for the result and consumes it; lat = -1 on timeout.
  task automatic run_word(input logic [7:0] w, output logic [3:0] cnt, output logic fnd,
                          output logic [2:0] pos, output int lat);
    int guard;
    in_word  = w;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    guard    = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    lat = out_valid ? guard : -1;
    cnt = out_count;
    fnd = out_found;
    pos = out_first_pos;
    if (out_valid) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    if (out_found !== 1'b0 || out_first_pos !== 3'd0) begin
      errors++;
      $display("FAIL reset_found_pos got %b/%0d want 0/0", out_found, out_first_pos);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_default_match();
    logic [3:0] c; logic f; logic [2:0] p; int l;
    run_word(8'b1011_0110, c, f, p, l);
    checks += 6;
    // Sampled after edge T+8, i.e. during cycle T+9 counting the accept cycle as T.
    if (l !== 8) begin errors++; $display("FAIL default_latency got %0d want 8 edges", l); end
    if (c !== 4'd2) begin errors++; $display("FAIL default_count got %0d want 2", c); end
    if (f !== 1'b1) begin errors++; $display("FAIL default_found got %b want 1", f); end
    if (p !== 3'd3) begin errors++; $display("FAIL default_pos got %0d want 3", p); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL default_consumed got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL default_idle got %b want 1", in_ready); end
  endtask

  task automatic test_non_overlap();
    logic [3:0] c; logic f; logic [2:0] p; int l;
    write_cfg(4'b1011, 1'b0);
    run_word(8'b1011_0110, c, f, p, l);
    checks += 3;
    if (l !== 8) begin errors++; $display("FAIL nonovl_latency got %0d want 8", l); end
    if (c !== 4'd1) begin errors++; $display("FAIL nonovl_count got %0d want 1", c); end
    if (p !== 3'd3) begin errors++; $display("FAIL nonovl_pos got %0d want 3", p); end
  endtask

  task automatic test_no_match_and_config();
    logic [3:0] c; logic f; logic [2:0] p; int l;
    run_word(8'hFF, c, f, p, l);
    checks += 3;
    if (c !== 4'd0) begin errors++; $display("FAIL nomatch_count got %0d want 0", c); end
    if (f !== 1'b0) begin errors++; $display("FAIL nomatch_found got %b want 0", f); end
    if (p !== 3'd0) begin errors++; $display("FAIL nomatch_pos got %0d want 0", p); end
    // Config written in the same cycle as the word is accepted.
    cfg_we      = 1'b1;
    cfg_pattern = 4'b0110;
    cfg_overlap = 1'b1;
    run_word(8'b0110_0110, c, f, p, l);
    cfg_we = 1'b0;
    checks += 3;
    if (c !== 4'd2) begin errors++; $display("FAIL newcfg_count got %0d want 2", c); end
    if (f !== 1'b1) begin errors++; $display("FAIL newcfg_found got %b want 1", f); end
    if (p !== 3'd3) begin errors++; $display("FAIL newcfg_pos got %0d want 3", p); end
  endtask

  task automatic test_backpressure();
    int guard;
    write_cfg(4'b1011, 1'b1);
    in_word  = 8'b1011_0110;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard    = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_word  = 8'hFF;
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      if (out_count !== 4'd2 || out_first_pos !== 3'd3) begin
        errors++;
        $display("FAIL bp_stable got %0d/%0d want 2/3", out_count, out_first_pos);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got %b want 0", out_valid); end
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_illegal_cfg();
    logic [3:0] c; logic f; logic [2:0] p; int l;
    write_cfg(4'b1011, 1'b1);
    in_word  = 8'b1011_1011;
    in_valid = 1'b1;
    tick();
    in_valid    = 1'b0;
    cfg_we      = 1'b1;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b0;
    tick();
    tick();
    tick();
    cfg_we = 1'b0;
    l = 0;
    while (!out_valid && l < 40) begin
      tick();
      l++;
    end
    checks += 2;
    if (out_count !== 4'd2) begin errors++; $display("FAIL illcfg_count got %0d want 2", out_count); end
    if (out_first_pos !== 3'd3) begin errors++; $display("FAIL illcfg_pos got %0d want 3", out_first_pos); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // Overlap=0 would give 1 here, pattern 0000 would give 0.
    run_word(8'b1011_0110, c, f, p, l);
    checks += 2;
    if (c !== 4'd2) begin errors++; $display("FAIL illcfg_next_count got %0d want 2", c); end
    if (p !== 3'd3) begin errors++; $display("FAIL illcfg_next_pos got %0d want 3", p); end
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0] c; logic f; logic [2:0] p; int l;
    logic stale;
    write_cfg(4'b0110, 1'b0);
    in_word  = 8'b1011_0110;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale got %b want 0", stale); end
    // Pattern 0110 would report first_pos 4; reset pattern 1011 reports 3.
    run_word(8'b1011_0110, c, f, p, l);
    checks += 3;
    if (l !== 8) begin errors++; $display("FAIL midrst_latency got %0d want 8", l); end
    if (c !== 4'd2) begin errors++; $display("FAIL midrst_count got %0d want 2", c); end
    if (p !== 3'd3) begin errors++; $display("FAIL midrst_pos got %0d want 3", p); end
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b1;
    in_valid    = 1'b0;
    in_word     = 8'h00;
    out_ready   = 1'b0;
    test_reset();
    test_default_match();
    test_non_overlap();
    test_no_match_and_config();
    test_backpressure();
    test_illegal_cfg();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
